// File: rtl/data_memory_mmio.sv
// Data-side memory for the single-cycle core: word-addressed RAM plus an MMIO window
// (tohost halt register, console byte FIFO with ready/valid drain, 64-bit cycle counter).
`timescale 1ns/1ps
module data_memory_mmio #(
   parameter int RAM_ADDR_W = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] address,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        halt,
   output logic [31:0] halt_code,
   output logic        tx_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [3:0] OFS_TOHOST   = 4'h0;
   localparam logic [3:0] OFS_CONSOLE  = 4'h4;
   localparam logic [3:0] OFS_CYCLE_LO = 4'h8;
   localparam logic [3:0] OFS_CYCLE_HI = 4'hC;

   logic [31:0] ram [0:(1<<RAM_ADDR_W)-1];
   logic [7:0]  fifo [0:FIFO_DEPTH-1];

   logic [PTR_W:0]  wr_ptr, rd_ptr;
   logic [63:0]     cycle_count;

   logic [RAM_ADDR_W-1:0] ram_index;
   logic is_mmio, mmio_hit;
   logic sel_tohost, sel_console, sel_cycle_lo, sel_cycle_hi;
   logic empty, full, pop, push_req, push, drop;

   // Byte offset within a word is irrelevant: every access is a full word.
   logic unused_addr_bits;
   assign unused_addr_bits = ^address[1:0];

   assign ram_index    = address[RAM_ADDR_W+1:2];
   assign is_mmio      = (address[31:28] == 4'hF);
   assign mmio_hit     = is_mmio && (address[27:4] == 24'd0);
   assign sel_tohost   = mmio_hit && (address[3:0] == OFS_TOHOST);
   assign sel_console  = mmio_hit && (address[3:0] == OFS_CONSOLE);
   assign sel_cycle_lo = mmio_hit && (address[3:0] == OFS_CYCLE_LO);
   assign sel_cycle_hi = mmio_hit && (address[3:0] == OFS_CYCLE_HI);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : fifo[rd_ptr[PTR_W-1:0]];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign pop      = tx_valid && tx_ready;
   assign push_req = mem_write && sel_console && !halt;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   // NOTE: every output of a combinational block gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      mem_read_data = 32'd0;
      if (mem_read) begin
         if (!is_mmio)          mem_read_data = ram[ram_index];
         else if (sel_tohost)   mem_read_data = halt_code;
         else if (sel_console)  mem_read_data = {29'd0, tx_overflow, full, empty};
         else if (sel_cycle_lo) mem_read_data = cycle_count[31:0];
         else if (sel_cycle_hi) mem_read_data = cycle_count[63:32];
      end
   end

   // NOTE: storage arrays carry no reset; RAM must survive rst and stale FIFO slots
   // are unreachable once the pointers clear.
   always_ff @(posedge clock) begin
      if (mem_write && !is_mmio && !halt)
         ram[ram_index] <= mem_write_data;
   end

   always_ff @(posedge clock) begin
      if (push)
         fifo[wr_ptr[PTR_W-1:0]] <= mem_write_data[7:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees
   // pre-edge values, which is what gives reads the old data on a same-cycle write.
   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         halt        <= 1'b0;
         halt_code   <= 32'd0;
         tx_overflow <= 1'b0;
         cycle_count <= 64'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop) tx_overflow <= 1'b1;
         // First nonzero tohost code wins; the whole machine freezes behind it.
         if (mem_write && sel_tohost && !halt && (mem_write_data != 32'd0)) begin
            halt      <= 1'b1;
            halt_code <= mem_write_data;
         end
         if (!halt) cycle_count <= cycle_count + 64'd1;
      end
   end

endmodule
